// File: rtl/aes_block_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// aes_uart_pkg
// Shared types and sizes for the AES ciphertext UART transmitter.
//   uart_state_t    : transmitter FSM states (PARITY is used only when
//                     AES_UART_TX_PARITY_EN is defined)
//   AES_BLOCK_W     : ciphertext block width in bits
//   UART_BYTE_W     : data bits per UART character
//   AES_BLOCK_BYTES : characters sent per block
// ---------------------------------------------------------------------------
package aes_uart_pkg;

   localparam int AES_BLOCK_W     = 128;
   localparam int UART_BYTE_W     = 8;
   localparam int AES_BLOCK_BYTES = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // Even parity of one character: the XOR of its data bits.
   function automatic logic evenParity(input logic [UART_BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/aes_block_uart_tx_if.sv
// ---------------------------------------------------------------------------
// aes_block_uart_tx_if
// Bundles the block hand-off from the encryption core and the UART side.
//   encoded_data  : 128-bit ciphertext block
//   encoded_state : block-valid level; only its rising edge matters
//   tx            : UART serial line, idle high
//   busy          : a frame is in progress
//   done          : one-cycle pulse when the last stop bit ends
// Modports: master = encryption core / bench, slave = transmitter.
// ---------------------------------------------------------------------------
interface aes_block_uart_tx_if;
   import aes_uart_pkg::*;

   logic [AES_BLOCK_W-1:0] encoded_data;
   logic                   encoded_state;
   logic                   tx;
   logic                   busy;
   logic                   done;

   modport master (
      output encoded_data,
      output encoded_state,
      input  tx,
      input  busy,
      input  done
   );

   modport slave (
      input  encoded_data,
      input  encoded_state,
      output tx,
      output busy,
      output done
   );

endinterface

// File: rtl/aes_block_uart_tx_baud.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-time counter. Counts 0..clock_per_bit-1 and wraps; o_tick is high in
// the terminal-count cycle, which is the last cycle of the current bit.
//   clk, rst      : clock, asynchronous active-high reset
//   i_clear       : synchronous restart of the count at 0
//   o_tick        : one-cycle bit-boundary pulse
// Parameter clock_per_bit must be >= 2.
// ---------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int clock_per_bit = 10417
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = $clog2(clock_per_bit);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(clock_per_bit - 1);

   logic [CNT_W-1:0] r_count;

   // The count restarts whenever the FSM enters a new state, and wraps at
   // the terminal count so consecutive bits of a state need no restart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tick = (r_count == TERMINAL);

endmodule

// File: rtl/aes_block_uart_tx.sv
// ---------------------------------------------------------------------------
// aes_block_uart_tx
// Captures a 128-bit ciphertext block on the rising edge of encoded_state
// and sends it as 16 UART characters, most significant byte first, each
// LSB first with no gap between characters.
//   clk, rst : clock, asynchronous active-high reset (tx returns high at once)
//   bus      : aes_block_uart_tx_if.slave (encoded_data, encoded_state in;
//              tx, busy, done out)
// Parameter clock_per_bit : clock cycles per UART bit, >= 2.
// Macro AES_UART_TX_PARITY_EN : adds an even-parity bit after the data bits.
// ---------------------------------------------------------------------------
module aes_block_uart_tx
   import aes_uart_pkg::*;
#(
   parameter int clock_per_bit = 10417
) (
   input  logic                clk,
   input  logic                rst,
   aes_block_uart_tx_if.slave  bus
);

   uart_state_t r_state;
   uart_state_t w_nextState;

   logic [AES_BLOCK_W-1:0] r_shift;
   logic [2:0]             r_bitCnt;
   logic [3:0]             r_byteCnt;
   logic                   r_stateQ;
   logic                   r_done;

   logic                   w_edge;
   logic                   w_tick;
   logic                   w_clear;
   logic                   w_load;
   logic                   w_shiftByte;
   logic                   w_doneNext;
   logic                   w_tx;
   logic [UART_BYTE_W-1:0] w_curByte;

   // The character being sent always sits in the top byte of the shift
   // register; the register moves left one byte after each stop bit.
   assign w_edge    = bus.encoded_state & ~r_stateQ;
   assign w_curByte = r_shift[AES_BLOCK_W-1 -: UART_BYTE_W];

   // Hold the bit timer at zero while idle and restart it on every state
   // change so the first bit of each state gets a full bit time.
   assign w_clear = (r_state == IDLE) || (w_nextState != r_state);

   uart_baud_tick #(
      .clock_per_bit (clock_per_bit)
   ) baudTick (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   // Next-state and line decode. tx is decoded straight from the state so
   // an asynchronous reset forces the line high without waiting for a clock.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_shiftByte = 1'b0;
      w_doneNext  = 1'b0;
      w_tx        = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_edge) begin
               w_nextState = START;
               w_load      = 1'b1;
            end
         end
         START: begin
            w_tx = 1'b0;
            if (w_tick) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            w_tx = w_curByte[r_bitCnt];
            if (w_tick && (r_bitCnt == 3'd7)) begin
`ifdef AES_UART_TX_PARITY_EN
               w_nextState = PARITY;
`else
               w_nextState = STOP;
`endif
            end
         end
`ifdef AES_UART_TX_PARITY_EN
         PARITY: begin
            w_tx = evenParity(w_curByte);
            if (w_tick) begin
               w_nextState = STOP;
            end
         end
`endif
         STOP: begin
            if (w_tick) begin
               if (r_byteCnt != 4'(AES_BLOCK_BYTES - 1)) begin
                  w_nextState = START;
                  w_shiftByte = 1'b1;
               end else begin
                  w_nextState = IDLE;
                  w_doneNext  = 1'b1;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register plus the edge detector. r_stateQ resets high so a valid
   // level already present when reset is released is not taken as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_stateQ <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_stateQ <= bus.encoded_state;
         r_done   <= w_doneNext;
      end
   end

   // Block shift register and the bit/byte position counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_byteCnt <= '0;
         r_bitCnt  <= '0;
      end else begin
         if (w_load) begin
            r_shift   <= bus.encoded_data;
            r_byteCnt <= '0;
         end else if (w_shiftByte) begin
            r_shift   <= r_shift << UART_BYTE_W;
            r_byteCnt <= r_byteCnt + 4'd1;
         end
         if (r_state != DATA) begin
            r_bitCnt <= '0;
         end else if (w_tick) begin
            r_bitCnt <= r_bitCnt + 3'd1;
         end
      end
   end

   assign bus.tx   = w_tx;
   assign bus.busy = (r_state != IDLE);
   assign bus.done = r_done;

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_aes_block_uart_tx
// Self-checking bench for aes_block_uart_tx with clock_per_bit = 4.
// A queue-based model expands each accepted block into the expected line
// waveform; a compare process checks tx/busy/done every cycle against it.
// Honours AES_UART_TX_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_aes_block_uart_tx;
   import aes_uart_pkg::*;

   localparam int CPB = 4;
`ifdef AES_UART_TX_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int FRAME = AES_BLOCK_BYTES * BITS * CPB;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   bit   mQ[$];
   bit   mPrev = 1'b1;
   bit   mDone = 1'b0;

   aes_block_uart_tx_if busIf();

   aes_block_uart_tx #(
      .clock_per_bit (CPB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
         end
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Expand one block into per-cycle line levels: start, 8 data bits LSB
   // first, optional even parity, stop; each level lasts CPB cycles.
   function automatic void pushFrame(input logic [127:0] d);
      logic [7:0] by;
      bit         lvl;
      for (int b = 0; b < AES_BLOCK_BYTES; b++) begin
         by = d[127 - 8*b -: 8];
         for (int s = 0; s < BITS; s++) begin
            if (s == 0)            lvl = 1'b0;
            else if (s <= 8)       lvl = by[s-1];
            else if (s == BITS-1)  lvl = 1'b1;
            else                   lvl = ^by;
            for (int c = 0; c < CPB; c++) mQ.push_back(lvl);
         end
      end
   endfunction

   // Model: while a frame is queued, each clock consumes one level and the
   // cycle after the last level is the done cycle; when nothing is queued a
   // rising edge on encoded_state queues a new frame.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mQ.delete();
            mPrev = 1'b1;
            mDone = 1'b0;
         end else begin
            mDone = 1'b0;
            if (mQ.size() != 0) begin
               void'(mQ.pop_front());
               mDone = (mQ.size() == 0);
            end else if (busIf.encoded_state && !mPrev) begin
               pushFrame(busIf.encoded_data);
            end
            mPrev = busIf.encoded_state;
         end
      end
   end

   // Per-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("tx",   busIf.tx,   (mQ.size() != 0) ? mQ[0] : 1'b1);
         checkOutput("busy", busIf.busy, mQ.size() != 0);
         checkOutput("done", busIf.done, mDone);
      end
   end

   task automatic startBlock(input logic [127:0] d);
      busIf.encoded_data  = d;
      busIf.encoded_state = 1'b1;
   endtask

   task automatic applyStimulus(input logic [127:0] d);
      @(negedge clk);
      startBlock(d);
   endtask

   // Follows one frame sample by sample, decoding bytes (and parity) at mid
   // bit, optionally injecting a second edge, and ends in the done cycle.
   task automatic captureFrame(input int secondAt, input logic [127:0] secondData,
                               output logic [127:0] got, output logic [15:0] gotPar,
                               output logic [43:0] first);
      int s, slot, b, p;
      got    = '0;
      gotPar = '0;
      first  = '0;
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         s = k - 1;
         if (s < 44) first[s] = busIf.tx;
         if (k == 1) begin
            checkOutput("startTx",   busIf.tx,   1'b0);
            checkOutput("startBusy", busIf.busy, 1'b1);
         end
         slot = s / CPB;
         if ((s % CPB) == 2) begin
            b = slot / BITS;
            p = slot % BITS;
            if (p >= 1 && p <= 8) got[120 - 8*b + p - 1] = busIf.tx;
            if (BITS == 11 && p == 9) gotPar[b] = busIf.tx;
         end
         if (k == 10) begin
            busIf.encoded_state = 1'b0;
            busIf.encoded_data  = rand128();
         end
         if (secondAt != 0 && k == secondAt) startBlock(secondData);
         if (secondAt != 0 && k == secondAt + 10) busIf.encoded_state = 1'b0;
      end
      @(negedge clk);
      checkOutput("doneAtEnd", busIf.done, 1'b1);
      checkOutput("busyAtEnd", busIf.busy, 1'b0);
   endtask

   initial begin
      logic [127:0] d, d2, got, got2;
      logic [15:0]  gotPar;
      logic [43:0]  first;
      logic [10:0]  seqLit;
      int           gap, sec;

      rst                 = 1'b1;
      busIf.encoded_state = 1'b1;
      busIf.encoded_data  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      $display("[TB] level held high through reset");
      repeat (20) @(negedge clk);
      checkOutput("heldHighTx",   busIf.tx,   1'b1);
      checkOutput("heldHighBusy", busIf.busy, 1'b0);
      busIf.encoded_state = 1'b0;

      $display("[TB] byte order and frame length");
      applyStimulus(128'h000102030405060708090A0B0C0D0E0F);
      captureFrame(0, '0, got, gotPar, first);
      for (int b = 0; b < 16; b++) checkOutput("byteOrder", got[127 - 8*b -: 8], b);

      $display("[TB] 0xA5 line sequence");
      d = rand128();
      d[127:120] = 8'hA5;
`ifdef AES_UART_TX_PARITY_EN
      seqLit = 11'b101_0100_1010;
`else
      seqLit = 11'b011_0100_1010;
`endif
      applyStimulus(d);
      captureFrame(0, '0, got, gotPar, first);
      for (int s = 0; s < BITS*CPB; s++) checkOutput("a5Seq", first[s], seqLit[s/CPB]);
      checkOutput("a5Frame", got, d);

      $display("[TB] second edge during frame");
      d  = rand128();
      d2 = ~d;
      applyStimulus(d);
      captureFrame(100, d2, got, gotPar, first);
      checkOutput("ignoreSecond", got, d);
      repeat (50) @(negedge clk);
      checkOutput("idleAfterIgnore", busIf.busy, 1'b0);

      $display("[TB] back-to-back blocks");
      d  = rand128();
      d2 = rand128();
      applyStimulus(d);
      captureFrame(0, '0, got, gotPar, first);
      startBlock(d2);
      captureFrame(0, '0, got2, gotPar, first);
      checkOutput("b2bFirst",  got,  d);
      checkOutput("b2bSecond", got2, d2);

      $display("[TB] reset during byte 7");
      applyStimulus(rand128());
      for (int k = 1; k <= 7*BITS*CPB + 6; k++) begin
         @(negedge clk);
         if (k == 10) busIf.encoded_state = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      checkOutput("rstTx",   busIf.tx,   1'b1);
      checkOutput("rstBusy", busIf.busy, 1'b0);
      checkOutput("rstDone", busIf.done, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      d = rand128();
      applyStimulus(d);
      captureFrame(0, '0, got, gotPar, first);
      checkOutput("afterReset", got, d);

`ifdef AES_UART_TX_PARITY_EN
      $display("[TB] parity bits");
      d = rand128();
      d[127:112] = 16'h0703;
      applyStimulus(d);
      captureFrame(0, '0, got, gotPar, first);
      checkOutput("parity07", gotPar[0], 1'b1);
      checkOutput("parity03", gotPar[1], 1'b0);
`endif

      $display("[TB] randomized blocks");
      for (int n = 0; n < 4; n++) begin
         gap = $urandom_range(0, 30);
         repeat (gap) @(negedge clk);
         d   = rand128();
         sec = ($urandom_range(0, 1) == 1) ? $urandom_range(20, FRAME - 20) : 0;
         applyStimulus(d);
         captureFrame(sec, rand128(), got, gotPar, first);
         checkOutput("randFrame", got, d);
`ifdef AES_UART_TX_PARITY_EN
         for (int b = 0; b < 16; b++) checkOutput("randParity", gotPar[b], ^d[127 - 8*b -: 8]);
`endif
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
